// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the single-port SRAM arbiter and its
// round-robin picker.
package sram_arb_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   localparam int SRAM_WORDS = 64;
   localparam int SRAM_AW    = 7;
   localparam int DATA_W     = 21;

endpackage

// File: rtl/sram_rr_arb.sv
// Combinational round-robin picker: the first valid requester at or above
// ptr (wrapping) wins; the pointer register lives in the caller.
module sram_rr_arb #(
   parameter int N_REQ = 2,
   parameter int PTR_W = 1
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] win
);

   logic [PTR_W-1:0] idx;

   // NOTE: every output gets a default before any conditional assignment,
   // so no path through the block leaves a value held (no latch inferred).
   always_comb begin
      grant = '0;
      win   = '0;
      idx   = '0;
      // Walk offsets downward so the nearest requester to ptr is written last.
      for (int off = N_REQ - 1; off >= 0; off--) begin
         idx = PTR_W'((int'(ptr) + off) % N_REQ);
         if (valid[idx]) win = idx;
      end
      if (|valid) grant[win] = 1'b1;
   end

endmodule

// File: rtl/sram_1rw_arbiter.sv
// Shares the single RW port of a 64-word SRAM macro between N_REQ requesters,
// zero-filling the array after reset. Define SRAM_ARB_PARITY_EN to store and check parity in bit DATA_W.
module sram_1rw_arbiter #(
   parameter int N_REQ   = 2,
   parameter int DATA_W  = sram_arb_pkg::DATA_W,
   parameter int ADDR_W  = 6,
   parameter int SRAM_AW = sram_arb_pkg::SRAM_AW
) (
   input  logic                    clk0,
   input  logic                    rstb0,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic                    rsp_err,
   output logic                    init_done,
   output logic                    csb0,
   output logic                    web0,
   output logic                    spare_wen0,
   output logic [SRAM_AW-1:0]      addr0,
   output logic [DATA_W:0]         din0,
   input  logic [DATA_W:0]         dout0
);
   import sram_arb_pkg::*;

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
`ifdef SRAM_ARB_PARITY_EN
   localparam logic PAR_EN = 1'b1;
`else
   localparam logic PAR_EN = 1'b0;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]  rsp_valid_q, rsp_valid_d;

   logic [N_REQ-1:0]  grant;
   logic [PTR_W-1:0]  win;
   logic [ADDR_W-1:0] addr_a  [N_REQ];
   logic [DATA_W-1:0] wdata_a [N_REQ];

   logic               csb_c, web_c, spare_c, win_we;
   logic [SRAM_AW-1:0] addr_c;
   logic [DATA_W:0]    din_c;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign addr_a[g]  = req_addr[g*ADDR_W +: ADDR_W];
      assign wdata_a[g] = req_wdata[g*DATA_W +: DATA_W];
   end

   sram_rr_arb #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_arb (
      .valid (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant),
      .win   (win)
   );

   assign win_we = req_we[win];

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = '0;
      req_ready   = '0;
      csb_c       = 1'b1;
      web_c       = 1'b1;
      spare_c     = 1'b0;
      addr_c      = '0;
      din_c       = '0;
      case (state_q)
         INIT: begin
            csb_c      = 1'b0;
            web_c      = 1'b0;
            spare_c    = PAR_EN;
            addr_c     = SRAM_AW'(init_cnt_q);
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == ADDR_W'(SRAM_WORDS - 1)) state_d = RUN;
         end
         RUN: begin
            if (|req_valid) begin
               req_ready           = grant;
               csb_c               = 1'b0;
               web_c               = ~win_we;
               spare_c             = PAR_EN & win_we;
               addr_c              = SRAM_AW'(addr_a[win]);
               din_c[DATA_W-1:0]   = wdata_a[win];
               din_c[DATA_W]       = PAR_EN & (^wdata_a[win]);
               rsp_valid_d         = win_we ? '0 : grant;
               rr_ptr_d            = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk0 or negedge rstb0) begin
      if (!rstb0) begin
         state_q     <= INIT;
         init_cnt_q  <= '0;
         rr_ptr_q    <= '0;
         rsp_valid_q <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // The reset state is INIT, which would enable the macro, so reset itself
   // forces the chip select and write enable inactive.
   assign csb0       = csb_c | ~rstb0;
   assign web0       = web_c | ~rstb0;
   assign spare_wen0 = spare_c & rstb0;
   assign addr0      = addr_c;
   assign din0       = din_c;

   assign init_done  = (state_q == RUN);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = dout0[DATA_W-1:0];

`ifdef SRAM_ARB_PARITY_EN
   assign rsp_err = (|rsp_valid_q) & (^dout0);
`else
   logic unused_dout_par;
   assign unused_dout_par = dout0[DATA_W];
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_1rw_arbiter.sv
// Directed bench for sram_1rw_arbiter with a behavioural 64x22 SRAM model;
// table-driven run-mode vectors plus init, reset and parity sequences.
module tb_sram_1rw_arbiter;

`ifdef SRAM_ARB_PARITY_EN
   localparam logic PAR = 1'b1;
`else
   localparam logic PAR = 1'b0;
`endif

   logic        clk0 = 1'b0;
   logic        rstb0;
   logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
   logic [11:0] req_addr;
   logic [41:0] req_wdata;
   logic [20:0] rsp_rdata;
   logic        rsp_err, init_done, csb0, web0, spare_wen0;
   logic [6:0]  addr0;
   logic [21:0] din0, dout0, dout_q;
   logic        flip;
   logic [21:0] mem [64];

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk0 = ~clk0;

   sram_1rw_arbiter dut (
      .clk0       (clk0),
      .rstb0      (rstb0),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .init_done  (init_done),
      .csb0       (csb0),
      .web0       (web0),
      .spare_wen0 (spare_wen0),
      .addr0      (addr0),
      .din0       (din0),
      .dout0      (dout0)
   );

   // Behavioural macro: synchronous write or read on csb0 low, dout held otherwise.
   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 22'h2AAAAA;
      dout_q = '0;
   end
   always @(posedge clk0) begin
      if (!csb0) begin
         if (!web0) mem[addr0[5:0]] <= din0;
         else       dout_q <= mem[addr0[5:0]];
      end
   end
   assign dout0 = dout_q ^ {flip, 21'h0};

   typedef struct {
      logic [1:0]  valid;
      logic [1:0]  we;
      logic [5:0]  a0, a1;
      logic [20:0] w0, w1;
      logic [1:0]  e_ready;
      logic        e_csb;
      logic        e_web;
      logic [5:0]  e_addr;
      logic [20:0] e_din;
      logic [1:0]  e_rsp;
      logic [20:0] e_rdata;
   } vec_t;

   vec_t tv [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [5:0] a0,
                        input logic [5:0] a1, input logic [20:0] w0, input logic [20:0] w1);
      req_valid = v;
      req_we    = w;
      req_addr  = {a1, a0};
      req_wdata = {w1, w0};
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, 6'd0, 6'd0, 21'h0, 21'h0);
   endtask

   task automatic cycle();
      @(posedge clk0);
      #1;
   endtask

   initial begin
      int n;

      //            valid  we     a0     a1      w0         w1         ready  csb   web   addr    din        rsp    rdata
      tv[0]  = '{2'b01, 2'b01, 6'd5, 6'd0,  21'h15A5A, 21'h0,     2'b01, 1'b0, 1'b0, 6'd5,  21'h15A5A, 2'b00, 21'h0};
      tv[1]  = '{2'b01, 2'b00, 6'd5, 6'd0,  21'h0,     21'h0,     2'b01, 1'b0, 1'b1, 6'd5,  21'h0,     2'b00, 21'h0};
      tv[2]  = '{2'b00, 2'b00, 6'd0, 6'd0,  21'h0,     21'h0,     2'b00, 1'b1, 1'b1, 6'd0,  21'h0,     2'b01, 21'h15A5A};
      tv[3]  = '{2'b10, 2'b10, 6'd0, 6'd7,  21'h0,     21'h0ABCD, 2'b10, 1'b0, 1'b0, 6'd7,  21'h0ABCD, 2'b00, 21'h0};
      tv[4]  = '{2'b11, 2'b00, 6'd5, 6'd7,  21'h0,     21'h0,     2'b01, 1'b0, 1'b1, 6'd5,  21'h0,     2'b00, 21'h0};
      tv[5]  = '{2'b11, 2'b00, 6'd5, 6'd7,  21'h0,     21'h0,     2'b10, 1'b0, 1'b1, 6'd7,  21'h0,     2'b01, 21'h15A5A};
      tv[6]  = '{2'b11, 2'b00, 6'd5, 6'd7,  21'h0,     21'h0,     2'b01, 1'b0, 1'b1, 6'd5,  21'h0,     2'b10, 21'h0ABCD};
      tv[7]  = '{2'b11, 2'b00, 6'd5, 6'd7,  21'h0,     21'h0,     2'b10, 1'b0, 1'b1, 6'd7,  21'h0,     2'b01, 21'h15A5A};
      tv[8]  = '{2'b00, 2'b00, 6'd0, 6'd0,  21'h0,     21'h0,     2'b00, 1'b1, 1'b1, 6'd0,  21'h0,     2'b10, 21'h0ABCD};
      tv[9]  = '{2'b11, 2'b01, 6'd3, 6'd3,  21'h1FFFFF,21'h0,     2'b01, 1'b0, 1'b0, 6'd3,  21'h1FFFFF,2'b00, 21'h0};
      tv[10] = '{2'b10, 2'b00, 6'd0, 6'd3,  21'h0,     21'h0,     2'b10, 1'b0, 1'b1, 6'd3,  21'h0,     2'b00, 21'h0};
      tv[11] = '{2'b00, 2'b00, 6'd0, 6'd0,  21'h0,     21'h0,     2'b00, 1'b1, 1'b1, 6'd0,  21'h0,     2'b10, 21'h1FFFFF};
      tv[12] = '{2'b01, 2'b00, 6'd3, 6'd0,  21'h0,     21'h0,     2'b01, 1'b0, 1'b1, 6'd3,  21'h0,     2'b00, 21'h0};
      tv[13] = '{2'b10, 2'b10, 6'd0, 6'd3,  21'h0,     21'h00123, 2'b10, 1'b0, 1'b0, 6'd3,  21'h00123, 2'b01, 21'h1FFFFF};
      tv[14] = '{2'b01, 2'b00, 6'd3, 6'd0,  21'h0,     21'h0,     2'b01, 1'b0, 1'b1, 6'd3,  21'h0,     2'b00, 21'h0};
      tv[15] = '{2'b00, 2'b00, 6'd0, 6'd0,  21'h0,     21'h0,     2'b00, 1'b1, 1'b1, 6'd0,  21'h0,     2'b01, 21'h00123};
      tv[16] = '{2'b10, 2'b00, 6'd0, 6'd63, 21'h0,     21'h0,     2'b10, 1'b0, 1'b1, 6'd63, 21'h0,     2'b00, 21'h0};
      tv[17] = '{2'b00, 2'b00, 6'd0, 6'd0,  21'h0,     21'h0,     2'b00, 1'b1, 1'b1, 6'd0,  21'h0,     2'b10, 21'h0};

      flip  = 1'b0;
      rstb0 = 1'b0;
      idle();

      // Reset state
      #12;
      check("rst csb0", 32'(csb0), 32'd1);
      check("rst web0", 32'(web0), 32'd1);
      check("rst req_ready", 32'(req_ready), 32'd0);
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst init_done", 32'(init_done), 32'd0);

      // Zero-fill: requests are presented throughout and must not be accepted
      drive(2'b11, 2'b11, 6'd9, 6'd9, 21'h12345, 21'h0F0F0);
      cycle();
      rstb0 = 1'b1;
      for (int k = 0; k < 64; k++) begin
         #1;
         check($sformatf("init addr0 k=%0d", k), 32'(addr0), 32'(k));
         check($sformatf("init web0 k=%0d", k), 32'(web0), 32'd0);
         check($sformatf("init csb0 k=%0d", k), 32'(csb0), 32'd0);
         check($sformatf("init din0 k=%0d", k), 32'(din0), 32'd0);
         check($sformatf("init ready k=%0d", k), 32'(req_ready), 32'd0);
         check($sformatf("init done k=%0d", k), 32'(init_done), 32'd0);
         cycle();
      end
      #1;
      check("init_done after 64", 32'(init_done), 32'd1);

      // Run-mode vectors
      for (int i = 0; i < 18; i++) begin
         drive(tv[i].valid, tv[i].we, tv[i].a0, tv[i].a1, tv[i].w0, tv[i].w1);
         #2;
         check($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(tv[i].e_ready));
         check($sformatf("v%0d csb0", i), 32'(csb0), 32'(tv[i].e_csb));
         check($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(tv[i].e_rsp));
         check($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'd0);
         check($sformatf("v%0d spare_wen0", i), 32'(spare_wen0),
               32'(PAR & ~tv[i].e_csb & ~tv[i].e_web));
         if (!tv[i].e_csb) begin
            check($sformatf("v%0d web0", i), 32'(web0), 32'(tv[i].e_web));
            check($sformatf("v%0d addr0", i), 32'(addr0), 32'({1'b0, tv[i].e_addr}));
            if (!tv[i].e_web)
               check($sformatf("v%0d din0", i), 32'(din0),
                     32'({PAR & (^tv[i].e_din), tv[i].e_din}));
         end
         if (tv[i].e_rsp != 2'b00)
            check($sformatf("v%0d rsp_rdata", i), 32'(rsp_rdata), 32'(tv[i].e_rdata));
         cycle();
      end

      // Reset one cycle after a read grant, with the request still asserted
      drive(2'b01, 2'b00, 6'd5, 6'd0, 21'h0, 21'h0);
      #2;
      check("pre-rst ready", 32'(req_ready), 32'd1);
      cycle();
      check("pre-rst rsp_valid", 32'(rsp_valid), 32'd1);
      rstb0 = 1'b0;
      #1;
      check("mid-rst csb0", 32'(csb0), 32'd1);
      check("mid-rst web0", 32'(web0), 32'd1);
      check("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid-rst init_done", 32'(init_done), 32'd0);
      cycle();
      rstb0 = 1'b1;
      idle();
      #1;
      check("restart addr0", 32'(addr0), 32'd0);
      check("restart csb0", 32'(csb0), 32'd0);
      check("restart web0", 32'(web0), 32'd0);
      n = 0;
      while (!init_done && n < 100) begin
         cycle();
         n++;
      end
      check("restart init cycles", 32'(n), 32'd64);

      // Address 5 held 0x15A5A before the reset; the refill must clear it
      drive(2'b01, 2'b00, 6'd5, 6'd0, 21'h0, 21'h0);
      cycle();
      idle();
      #1;
      check("post-refill rsp_valid", 32'(rsp_valid), 32'd1);
      check("post-refill rdata", 32'(rsp_rdata), 32'd0);

      // Parity: write 0x000001, read back clean and with dout0[21] inverted
      drive(2'b01, 2'b01, 6'd9, 6'd0, 21'h000001, 21'h0);
      #1;
      check("par write din0", 32'(din0), 32'({PAR, 21'h000001}));
      check("par write spare_wen0", 32'(spare_wen0), 32'(PAR));
      cycle();
      drive(2'b01, 2'b00, 6'd9, 6'd0, 21'h0, 21'h0);
      cycle();
      idle();
      #1;
      check("par clean rdata", 32'(rsp_rdata), 32'h1);
      check("par clean rsp_err", 32'(rsp_err), 32'd0);
      flip = 1'b1;
      #1;
      check("par flip rsp_valid", 32'(rsp_valid), 32'd1);
      check("par flip rsp_err", 32'(rsp_err), 32'(PAR));
      check("par spare idle", 32'(spare_wen0), 32'd0);
      flip = 1'b0;
      cycle();
      check("rsp_err after resp", 32'(rsp_err), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
